// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions: default widths, NOP encoding, entry layout, occupancy states.
package pipe_stage_skid_pkg;

    localparam int unsigned PIPE_ADDR_W = 32;
    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_CNT_W  = 16;

    // Payload presented downstream while the stage holds nothing valid.
    localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = '0;

    // One held stage entry at the default widths.
    typedef struct packed {
        logic [PIPE_ADDR_W-1:0] addr;
        logic [PIPE_DATA_W-1:0] data;
        logic                   valid;
    } stage_entry_t;

    // Occupancy states; the encoding is the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] value_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count events, stick at all-ones, clear on request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake, two-entry skid,
// flush-to-bubble, external stall and saturating stall/flush counters.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned      ADDR_W    = PIPE_ADDR_W,
    parameter int unsigned      DATA_W    = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(PIPE_NOP),
    parameter int unsigned      CNT_W     = PIPE_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              clr_cnt_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              valid;
    } entry_t;

    occ_state_e state_q;
    entry_t     m_q;
    entry_t     s_q;
    entry_t     in_entry_c;
    logic       in_go_c;
    logic       out_go_c;
    logic       stall_inc_c;
    logic       flush_inc_c;

    // Handshake qualifiers; ready depends on state only.
    assign in_ready_o  = ~s_q.valid;
    assign in_go_c     = in_valid_i & in_ready_o;
    assign out_go_c    = m_q.valid & out_ready_i & ~stall_i;
    assign in_entry_c  = {in_addr_i, in_data_i, 1'b1};

    // Occupancy FSM moving entries between input, skid and main registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush_i) begin
            state_q     <= ST_EMPTY;
            m_q.valid   <= 1'b0;
            s_q.valid   <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_go_c) begin
                        m_q     <= in_entry_c;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_go_c && out_go_c) begin
                        m_q <= in_entry_c;
                    end else if (out_go_c) begin
                        m_q.valid <= 1'b0;
                        state_q   <= ST_EMPTY;
                    end else if (in_go_c) begin
                        s_q     <= in_entry_c;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_go_c) begin
                        m_q       <= s_q;
                        s_q.valid <= 1'b0;
                        state_q   <= ST_ONE;
                    end
                end
                default: begin
                    m_q.valid <= 1'b0;
                    s_q.valid <= 1'b0;
                    state_q   <= ST_EMPTY;
                end
            endcase
        end
    end

    // Output view of the main register; invalid slots show the NOP payload.
    assign out_valid_o = m_q.valid;
    assign out_addr_o  = m_q.addr;
    assign out_data_o  = m_q.valid ? m_q.data : NOP_VALUE;
    assign occupancy_o = state_q;

    // Performance events: blocked valid output, and flushes that discard something.
    assign stall_inc_c = m_q.valid & ~out_go_c & ~flush_i;
    assign flush_inc_c = flush_i & (m_q.valid | s_q.valid);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (stall_inc_c),
        .clr_i   (clr_cnt_i),
        .value_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush_inc_c),
        .clr_i   (clr_cnt_i),
        .value_o (flush_cnt_o)
    );

endmodule
